// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one d_mem port between
// requester 0 (CPU LSU) and requester 1 (debug/DMA loader).
// Ports: clk, rst (async, active-low); reqX/weX/addrX/wdataX in;
// gntX (combinational), rvalidX/rdataX read return per requester;
// memRead/memWrite/dataAddress/writeMemData registered to d_mem;
// readMemData from d_mem.
// Build option: define DMEM_ARB_LOCK_EN to add lock0/lock1 inputs
// that let one requester hold the memory for a locked sequence.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] dataAddress,
  output logic [DATA_W-1:0] writeMemData,
  input  logic [DATA_W-1:0] readMemData
);

  logic ptr_q, ptr_d;
  logic el0, el1;
  logic g0, g1;
  logic acc;
  logic we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;

  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  // Tag pipeline: index 0 lines up with the strobe
  // cycle, index READ_LAT with the data-return cycle.
  logic [READ_LAT:0] tv_q, tv_d;
  logic [READ_LAT:0] to_q, to_d;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED0,
    LOCKED1
  } lock_e;

  lock_e lk_q, lk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lk_q <= UNLOCKED;
    else      lk_q <= lk_d;
  end

  always_comb begin
    lk_d = lk_q;
    el0  = req0 & (lk_q != LOCKED1);
    el1  = req1 & (lk_q != LOCKED0);
    unique case (lk_q)
      UNLOCKED: begin
        if (g0 & lock0)      lk_d = LOCKED0;
        else if (g1 & lock1) lk_d = LOCKED1;
      end
      LOCKED0: if (g0 & ~lock0) lk_d = UNLOCKED;
      LOCKED1: if (g1 & ~lock1) lk_d = UNLOCKED;
      default: lk_d = UNLOCKED;
    endcase
  end
`else
  always_comb begin
    el0 = req0;
    el1 = req1;
  end
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      (el0 & el1): begin
        g0 = ~ptr_q;
        g1 = ptr_q;
      end
      (el0 & ~el1): g0 = 1'b1;
      (~el0 & el1): g1 = 1'b1;
      default: ;
    endcase
  end

  // Grants are forced low while reset is held.
  assign gnt0 = g0 & rst;
  assign gnt1 = g1 & rst;

  assign acc     = g0 | g1;
  assign we_s    = g1 ? we1 : we0;
  assign addr_s  = g1 ? addr1 : addr0;
  assign wdata_s = g1 ? wdata1 : wdata0;

  always_comb begin
    ptr_d  = acc ? g0 : ptr_q;
    rd_d   = acc & ~we_s;
    wr_d   = acc & we_s;
    addr_d = acc ? addr_s : '0;
    wd_d   = acc ? wdata_s : '0;
    tv_d   = {tv_q[READ_LAT-1:0], acc & ~we_s};
    to_d   = {to_q[READ_LAT-1:0], g1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      tv_q   <= '0;
      to_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      tv_q   <= tv_d;
      to_q   <= to_d;
    end
  end

  assign memRead      = rd_q;
  assign memWrite     = wr_q;
  assign dataAddress  = addr_q;
  assign writeMemData = wd_q;

  assign rvalid0 = tv_q[READ_LAT] & ~to_q[READ_LAT];
  assign rvalid1 = tv_q[READ_LAT] & to_q[READ_LAT];
  assign rdata0  = readMemData;
  assign rdata1  = readMemData;

endmodule
